// File: rtl/video_composite_timing.sv
// NTSC-style 240p composite timing: line/frame counters, sync/burst/active decode,
// pixel-fetch request, and a delay line that realigns modulator controls with fetched pixels.
module video_composite_timing #(
    parameter int H_TOTAL        = 1588,
    parameter int H_SYNC         = 117,
    parameter int H_EQ           = 58,
    parameter int BURST_START    = 132,
    parameter int BURST_LEN      = 63,
    parameter int ACTIVE_START   = 244,
    parameter int ACTIVE_LEN     = 1280,
    parameter int V_TOTAL        = 262,
    parameter int V_ACTIVE_START = 21,
    parameter int V_ACTIVE_LEN   = 240,
    parameter int PIPE_DLY       = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        pixel_req,
    output logic [10:0] x,
    output logic [7:0]  y,
    output logic        frame_start,
    output logic        active,
    output logic        color_burst,
    output logic        sync_n
);

    localparam int HALF = H_TOTAL / 2;

    if (ACTIVE_START + ACTIVE_LEN > H_TOTAL) begin : g_bad_active
        $error("active window extends past end of line");
    end
    if (BURST_START < H_SYNC || BURST_START + BURST_LEN > ACTIVE_START) begin : g_bad_burst
        $error("burst gate overlaps hsync or active window");
    end
    if (V_ACTIVE_START < 9 || V_ACTIVE_START + V_ACTIVE_LEN > V_TOTAL) begin : g_bad_vactive
        $error("active lines overlap vertical sync region or exceed frame");
    end
    if (PIPE_DLY < 1 || PIPE_DLY > 15 || H_TOTAL > 2048 || V_TOTAL > 512) begin : g_bad_size
        $error("PIPE_DLY out of range or counters too narrow");
    end

    logic [10:0] h;
    logic [8:0]  v;
    int          hi, vi;
    logic        sync_raw_n, burst_raw, line_active, act_raw, first_raw;
    logic [10:0] x_raw;
    logic [7:0]  y_raw;

    // Raw decode from counter state
    always_comb begin
        hi = int'(h);
        vi = int'(v);
        if (vi <= 2 || (vi >= 6 && vi <= 8))
            sync_raw_n = !(hi < H_EQ || (hi >= HALF && hi < HALF + H_EQ));
        else if (vi >= 3 && vi <= 5)
            sync_raw_n = !(hi < HALF - H_SYNC || (hi >= HALF && hi < H_TOTAL - H_SYNC));
        else
            sync_raw_n = !(hi < H_SYNC);
        burst_raw   = vi >= 9 && hi >= BURST_START && hi < BURST_START + BURST_LEN;
        line_active = vi >= V_ACTIVE_START && vi < V_ACTIVE_START + V_ACTIVE_LEN;
        act_raw     = line_active && hi >= ACTIVE_START && hi < ACTIVE_START + ACTIVE_LEN;
        x_raw       = act_raw ? 11'(hi - ACTIVE_START) : 11'd0;
        y_raw       = line_active ? 8'(vi - V_ACTIVE_START) : 8'd0;
        first_raw   = h == 11'd0 && v == 9'd0;
    end

    // Stage 0 of each pipe is the pixel_req-domain register; stage PIPE_DLY feeds the modulator
    logic [PIPE_DLY:0] act_pipe, burst_pipe, sync_pipe_n;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            h           <= '0;
            v           <= '0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            act_pipe    <= '0;
            burst_pipe  <= '0;
            sync_pipe_n <= '1;
        end else begin
            if (h == 11'(H_TOTAL - 1)) begin
                h <= '0;
                v <= (v == 9'(V_TOTAL - 1)) ? 9'd0 : v + 9'd1;
            end else begin
                h <= h + 11'd1;
            end
            x           <= x_raw;
            y           <= y_raw;
            frame_start <= first_raw;
            act_pipe    <= {act_pipe[PIPE_DLY-1:0], act_raw};
            burst_pipe  <= {burst_pipe[PIPE_DLY-1:0], burst_raw};
            sync_pipe_n <= {sync_pipe_n[PIPE_DLY-1:0], sync_raw_n};
        end
    end

    assign pixel_req   = act_pipe[0];
    assign active      = act_pipe[PIPE_DLY];
    assign color_burst = burst_pipe[PIPE_DLY];
    assign sync_n      = sync_pipe_n[PIPE_DLY];

endmodule
